vector_add_arbiter: RTL and testbench
=====================================

# vector_add_arbiter

Shares a single `vector_add` datapath between `NUM_REQ` independent requesters, such as the transform, lighting and rasteriser setup stages of the graphics pipeline. Round-robin arbitration picks one request per cycle, captures its operands in a single pipeline register and presents the combinational `vector_add` result with a requester tag. Each response is held until the consumer accepts it.

## Interface
- `NUM_REQ`, default 4: number of requesters. Legal range is 2..16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the response tag. Derived; never overridden.
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst`  in  1: reset is synchronous and active-high. One clock; no other clock domain.
- `req_valid`  in  NUM_REQ: per-requester request valid.
- `req_ready`  out  NUM_REQ: per-requester accept. At most one bit is set in any cycle.
- `req_op1`  in  NUM_REQ × `vector::vector_t`: first operand per requester. Each `vector_t` is `{x,y,z}` of `fixed_point::fixed_point_t` (32-bit Q16.16), 96 bits.
- `req_op2`  in  NUM_REQ × `vector::vector_t`: second operand per requester.
- `resp_valid`  out  1: a result is presented.
- `resp_ready`  in  1: the consumer accepts the result.
- `resp_id`  out  ID_W: index of the requester that owns the result.
- `resp_result`  out  96: `vector_add` sum of the captured operands, `vector_t` layout.
- `resp_overflow`  out  1: OR of the x, y and z axis overflows for this result.
- `ovf_sticky`  out  1: accumulated overflow flag. Present only with `VECTOR_ADD_ARB_STICKY_OVF_EN`.
- `ovf_clear`  in  1: clears `ovf_sticky`. Present only with `VECTOR_ADD_ARB_STICKY_OVF_EN`.

## Operation
- **State machine:**
  - `IDLE`: the operand register is empty.
  - `HOLD`: the operand register is full and `resp_valid`=1.
- **Can-accept condition:** `accept_ok = (state==IDLE) | (state==HOLD & resp_ready)`.
- **Grant:**
  - The winner is the lowest index `i ≥ ptr` with `req_valid[i]`. The search wraps modulo `NUM_REQ`.
  - `req_ready[winner] = accept_ok`. All other `req_ready` bits are 0.
  - `req_ready` may depend combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- **Accept:** a request is accepted when `req_valid[i] & req_ready[i]`. On the next edge:
  - the operand register loads `req_op1[i]` and `req_op2[i]`;
  - the tag register loads `i`;
  - state becomes `HOLD`;
  - `ptr` becomes `(i+1) mod NUM_REQ`.
- **Pointer hold:** `ptr` is unchanged in any cycle with no accept.
- **Release:** `resp_valid & resp_ready` with no new accept sets state to `IDLE`. Release together with a new accept stays in `HOLD` with the new operands, giving throughput of one result per cycle.
- **Response:**
  - `resp_result` and `resp_overflow` are driven combinationally by one internal `vector_add` instance fed from the operand register.
  - `resp_id` is driven from the tag register.
  - All three are stable while `resp_valid & !resp_ready`.
- **Arithmetic:** wrap and overflow behaviour is exactly that of `fixed_point_add` per axis. The arbiter does not modify the sum.
- **Reset values:**
  - state=`IDLE`, `ptr`=0, operand and tag registers=0.
  - `resp_valid`=0, `req_ready`=0 while `rst`=1.
  - `resp_id`=0, `resp_result`=0 (0+0), `resp_overflow`=0.
  - `ovf_sticky`=0.
- **Reset mid-operation:** a held result is discarded without a handshake, and no `req_ready` is asserted during the reset cycle.

## Timing
- **Latency:** an accept at edge N gives `resp_valid`=1 in cycle N+1 (one cycle).
- **Back-pressure:** while `resp_ready`=0 in `HOLD`, all `req_ready`=0 and the outputs are frozen.
- **Fairness:** with all requesters continuously valid and `resp_ready`=1, grants rotate 0,1,…,NUM_REQ-1,0. Each requester waits at most `NUM_REQ-1` grants.
- **Single requester:** a single continuously valid requester is granted every cycle, regardless of `ptr`.
- **Critical path:** the combinational path from the operand register through the three `fixed_point_add` instances to the outputs is the accepted critical path. No output register is added.

## Configuration
- Macro: `VECTOR_ADD_ARB_STICKY_OVF_EN`.
- **Defined:**
  - the `ovf_sticky` and `ovf_clear` ports exist;
  - `ovf_sticky` sets on the edge after any cycle with `resp_valid & resp_ready & resp_overflow`;
  - `ovf_clear`=1 clears it on the next edge;
  - when set and clear coincide, set wins.
- **Undefined:** both ports and the register are absent. The other behaviour is identical.

## Test plan
- **Basic add:** after reset, `req_valid`=0b0001 with op1={0x00010000,0x00020000,0xFFFF0000} and op2={0x00010000,0x00010000,0x00010000}. Required: `req_ready`=0b0001. Next cycle: `resp_valid`=1, `resp_id`=0, `resp_result`={0x00020000,0x00030000,0x00000000}, `resp_overflow`=0.
- **Overflow:** op1.x=0x7FFF0000, op2.x=0x00010000, other axes 0. Required: `resp_overflow`=1. With the macro defined, `ovf_sticky`=1 after the handshake. `ovf_clear` together with a second overflowing handshake leaves `ovf_sticky`=1.
- **Round robin:** all four requesters valid, `resp_ready`=1, for 8 cycles. Required: `resp_id` sequence is 0,1,2,3,0,1,2,3 and exactly one `req_ready` bit is set each cycle.
- **Back-pressure:** `resp_ready`=0 for 5 cycles while requesters 1 and 2 are valid. Required: `resp_*` is frozen, `req_ready`=0. When `resp_ready` goes to 1, requester 1 is granted in the same cycle.
- **Reset mid-operation:** assert `rst` for 1 cycle while in `HOLD` with `resp_ready`=0. Required: `resp_valid`=0 and `resp_id`=0 the next cycle. The first grant after reset goes to requester 0 when all requesters are valid.

Source files
------------

// File: rtl/vector_add_arbiter.sv
// Round-robin arbiter sharing one vector_add datapath between NUM_REQ requesters.
// Latency: one cycle from request accept to resp_valid; result is combinational from the operand register.
// Backpressure: the response is held until resp_ready; no request is accepted while it is held.
// Optional sticky overflow flag (ovf_sticky/ovf_clear) is built when VECTOR_ADD_ARB_STICKY_OVF_EN is defined.

package fixed_point;
    // Q16.16 signed fixed point
    typedef logic [31:0] fixed_point_t;
endpackage

package vector;
    typedef struct packed {
        fixed_point::fixed_point_t x;
        fixed_point::fixed_point_t y;
        fixed_point::fixed_point_t z;
    } vector_t;
endpackage

// Wrapping Q16.16 add; overflow flags a signed result that does not fit.
module fixed_point_add (
    input  fixed_point::fixed_point_t a,
    input  fixed_point::fixed_point_t b,
    output fixed_point::fixed_point_t sum,
    output logic                      overflow
);
    assign sum      = a + b;
    // Signed overflow: operands agree in sign but the sum does not.
    assign overflow = (a[31] == b[31]) && (sum[31] != a[31]);
endmodule

// Per-axis fixed-point add of two vectors.
module vector_add (
    input  vector::vector_t a,
    input  vector::vector_t b,
    output vector::vector_t sum,
    output logic            overflow
);
    logic ovf_x;
    logic ovf_y;
    logic ovf_z;

    fixed_point_add u_add_x (.a(a.x), .b(b.x), .sum(sum.x), .overflow(ovf_x));
    fixed_point_add u_add_y (.a(a.y), .b(b.y), .sum(sum.y), .overflow(ovf_y));
    fixed_point_add u_add_z (.a(a.z), .b(b.z), .sum(sum.z), .overflow(ovf_z));

    assign overflow = ovf_x | ovf_y | ovf_z;
endmodule

module vector_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  vector::vector_t [NUM_REQ-1:0]     req_op1,
    input  vector::vector_t [NUM_REQ-1:0]     req_op2,
    output logic                              resp_valid,
    input  logic                              resp_ready,
    output logic [ID_W-1:0]                   resp_id,
    output vector::vector_t                   resp_result,
    output logic                              resp_overflow
`ifdef VECTOR_ADD_ARB_STICKY_OVF_EN
    ,
    output logic                              ovf_sticky,
    input  logic                              ovf_clear
`endif
);
    typedef logic [ID_W-1:0] id_t;

    localparam logic [0:0]  IDLE      = 1'b0;
    localparam logic [0:0]  HOLD      = 1'b1;
    localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam id_t         LAST_ID   = id_t'(NUM_REQ - 1);

    logic [0:0]      state;
    id_t             ptr;
    id_t             tag_q;
    vector::vector_t op1_q;
    vector::vector_t op2_q;

    logic            accept_ok;
    logic            accept;
    logic            grant_found;
    id_t             grant_id;
    logic [ID_W:0]   cand;

    assign accept_ok = (state == IDLE) || ((state == HOLD) && resp_ready);
    assign accept    = grant_found && accept_ok && !rst;

    // Search from ptr upwards, wrapping, for the first valid requester.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[ID_W-1:0];
            end
        end
    end

    // Only the winner sees ready, and only when the operand register can take it.
    always_comb begin
        req_ready           = '0;
        req_ready[grant_id] = accept;
    end

    // Control state: load on accept, drop to IDLE on a bare release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
        end else if (accept) begin
            state <= HOLD;
            ptr   <= (grant_id == LAST_ID) ? id_t'(0) : grant_id + 1'b1;
        end else if ((state == HOLD) && resp_ready) begin
            state <= IDLE;
        end
    end

    // Operand and tag capture for the winning requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            op1_q <= '0;
            op2_q <= '0;
            tag_q <= '0;
        end else if (accept) begin
            op1_q <= req_op1[grant_id];
            op2_q <= req_op2[grant_id];
            tag_q <= grant_id;
        end
    end

    vector_add u_vector_add (
        .a       (op1_q),
        .b       (op2_q),
        .sum     (resp_result),
        .overflow(resp_overflow)
    );

    // A held result is hidden during reset so it can never be handshaken.
    assign resp_valid = (state == HOLD) && !rst;
    assign resp_id    = tag_q;

`ifdef VECTOR_ADD_ARB_STICKY_OVF_EN
    // Accumulate overflow of delivered results; a new overflow beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (resp_valid && resp_ready && resp_overflow) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clear) begin
            ovf_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_vector_add_arbiter.sv
// Directed self-checking bench for vector_add_arbiter with NUM_REQ=4.
// Latency: checks registered outputs 1 time unit after each rising edge.
// Backpressure: exercises held responses, round robin, reset and single requester.
module tb_vector_add_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                          clk;
    logic                          rst;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    vector::vector_t [NUM_REQ-1:0] req_op1;
    vector::vector_t [NUM_REQ-1:0] req_op2;
    logic                          resp_valid;
    logic                          resp_ready;
    logic [ID_W-1:0]               resp_id;
    vector::vector_t               resp_result;
    logic                          resp_overflow;
`ifdef VECTOR_ADD_ARB_STICKY_OVF_EN
    logic                          ovf_sticky;
    logic                          ovf_clear;
`endif

    int checks   = 0;
    int failures = 0;

    vector_add_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op1      (req_op1),
        .req_op2      (req_op2),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_result  (resp_result),
        .resp_overflow(resp_overflow)
`ifdef VECTOR_ADD_ARB_STICKY_OVF_EN
        ,
        .ovf_sticky   (ovf_sticky),
        .ovf_clear    (ovf_clear)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rr_x [NUM_REQ];

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        req_op1    = '0;
        req_op2    = '0;
`ifdef VECTOR_ADD_ARB_STICKY_OVF_EN
        ovf_clear  = 1'b0;
`endif

        // Reset state; requests during reset must not be readied
        tick();
        tick();
        req_valid = 4'hF;
        #1;
        check("rst_req_ready", 128'(req_ready), 128'(4'b0000));
        check("rst_resp_valid", 128'(resp_valid), 128'(1'b0));
        check("rst_resp_id", 128'(resp_id), 128'(2'd0));
        check("rst_resp_result", 128'(resp_result), 128'(96'h0));
        check("rst_resp_overflow", 128'(resp_overflow), 128'(1'b0));
`ifdef VECTOR_ADD_ARB_STICKY_OVF_EN
        check("rst_ovf_sticky", 128'(ovf_sticky), 128'(1'b0));
`endif
        req_valid = '0;
        tick();
        rst = 1'b0;

        // Basic add on requester 0
        req_op1[0] = {32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000};
        req_op2[0] = {32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
        req_valid  = 4'b0001;
        #1;
        check("basic_req_ready", 128'(req_ready), 128'(4'b0001));
        tick();
        check("basic_resp_valid", 128'(resp_valid), 128'(1'b1));
        check("basic_resp_id", 128'(resp_id), 128'(2'd0));
        check("basic_resp_result", 128'(resp_result), 128'({32'h0002_0000, 32'h0003_0000, 32'h0000_0000}));
        check("basic_resp_overflow", 128'(resp_overflow), 128'(1'b0));
        req_valid  = '0;
        resp_ready = 1'b1;
        tick();
        check("basic_release", 128'(resp_valid), 128'(1'b0));

        // Overflow on requester 1 (ptr is now 1)
        req_op1[1] = {32'h7FFF_0000, 32'h0, 32'h0};
        req_op2[1] = {32'h0001_0000, 32'h0, 32'h0};
        req_op1[2] = {32'h7FFF_0000, 32'h0, 32'h0};
        req_op2[2] = {32'h0001_0000, 32'h0, 32'h0};
        req_valid  = 4'b0010;
        #1;
        check("ovf_req_ready", 128'(req_ready), 128'(4'b0010));
        tick();
        req_valid = '0;
        check("ovf_resp_id", 128'(resp_id), 128'(2'd1));
        check("ovf_resp_result", 128'(resp_result), 128'({32'h8000_0000, 32'h0, 32'h0}));
        check("ovf_resp_overflow", 128'(resp_overflow), 128'(1'b1));
`ifdef VECTOR_ADD_ARB_STICKY_OVF_EN
        check("sticky_before", 128'(ovf_sticky), 128'(1'b0));
`endif
        tick();
        check("ovf_release", 128'(resp_valid), 128'(1'b0));
`ifdef VECTOR_ADD_ARB_STICKY_OVF_EN
        check("sticky_set", 128'(ovf_sticky), 128'(1'b1));
`endif
        // Second overflow from requester 2, handshake coinciding with clear
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        check("ovf2_resp_id", 128'(resp_id), 128'(2'd2));
        check("ovf2_resp_overflow", 128'(resp_overflow), 128'(1'b1));
`ifdef VECTOR_ADD_ARB_STICKY_OVF_EN
        ovf_clear = 1'b1;
        tick();
        check("sticky_set_wins", 128'(ovf_sticky), 128'(1'b1));
        tick();
        check("sticky_cleared", 128'(ovf_sticky), 128'(1'b0));
        ovf_clear = 1'b0;
`else
        tick();
`endif

        // Round robin from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rr_x[0] = 32'h0001_8000;
        rr_x[1] = 32'h0002_8000;
        rr_x[2] = 32'h0003_8000;
        rr_x[3] = 32'h0004_8000;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_op1[i] = {32'h0001_0000 * 32'(i + 1), 32'h0, 32'h0};
            req_op2[i] = {32'h0000_8000, 32'h0, 32'h0};
        end
        req_valid  = 4'hF;
        resp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_req_ready", 128'(req_ready), 128'(4'b0001 << (k % 4)));
            tick();
            check("rr_resp_valid", 128'(resp_valid), 128'(1'b1));
            check("rr_resp_id", 128'(resp_id), 128'(k % 4));
            check("rr_resp_x", 128'(resp_result.x), 128'(rr_x[k % 4]));
        end

        // Back-pressure: held response from requester 3, requesters 1 and 2 waiting
        resp_ready = 1'b0;
        req_valid  = 4'b0110;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_req_ready", 128'(req_ready), 128'(4'b0000));
            check("bp_resp_valid", 128'(resp_valid), 128'(1'b1));
            check("bp_resp_id", 128'(resp_id), 128'(2'd3));
            check("bp_resp_x", 128'(resp_result.x), 128'(32'h0004_8000));
            tick();
        end
        resp_ready = 1'b1;
        #1;
        check("bp_release_grant", 128'(req_ready), 128'(4'b0010));
        tick();
        check("bp_next_id", 128'(resp_id), 128'(2'd1));

        // Reset while holding a result
        resp_ready = 1'b0;
        req_valid  = 4'hF;
        rst        = 1'b1;
        #1;
        check("midrst_req_ready", 128'(req_ready), 128'(4'b0000));
        tick();
        rst = 1'b0;
        check("midrst_resp_valid", 128'(resp_valid), 128'(1'b0));
        check("midrst_resp_id", 128'(resp_id), 128'(2'd0));
        #1;
        check("midrst_first_grant", 128'(req_ready), 128'(4'b0001));
        tick();
        check("midrst_first_id", 128'(resp_id), 128'(2'd0));
        check("midrst_first_valid", 128'(resp_valid), 128'(1'b1));

        // Single requester granted every cycle whatever the pointer
        resp_ready = 1'b1;
        req_valid  = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("single_req_ready", 128'(req_ready), 128'(4'b0100));
            tick();
            check("single_resp_id", 128'(resp_id), 128'(2'd2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
